// File: rtl/usb_rw_sequencer_if.sv
// Handshake between usb_rw_sequencer (master) and the USB protocol FSM (slave).
// Separate tx/rx data buses replace the old tri-state bus.
interface usb_rw_sequencer_if #(
    parameter int DATA_W = 64
);
    logic              input_ready;
    logic              send_in;
    logic [6:0]        addr;
    logic [3:0]        endp;
    logic [DATA_W-1:0] tx_data;
    logic              free;
    logic              xfer_done;
    logic              bad;
    logic [DATA_W-1:0] rx_data;

    modport master (
        output input_ready, send_in, addr, endp, tx_data,
        input  free, xfer_done, bad, rx_data
    );

    modport slave (
        input  input_ready, send_in, addr, endp, tx_data,
        output free, xfer_done, bad, rx_data
    );
endinterface

// File: rtl/usb_rw_sequencer.sv
// Memory-access sequencer: one address OUT, then a 1..2^BURST_W word IN/OUT burst.
// Define USB_RW_RETRY_EN to retry failed transactions up to MAX_RETRY times.
module usb_rw_sequencer #(
    parameter int         DATA_W    = 64,
    parameter int         PAGE_W    = 16,
    parameter int         BURST_W   = 3,
    parameter logic [6:0] DEV_ADDR  = 7'd5,
    parameter logic [3:0] ADDR_ENDP = 4'd4,
    parameter logic [3:0] DATA_ENDP = 4'd8,
    parameter int         MAX_RETRY = 3
) (
    input  logic               clk,
    input  logic               rst_L,
    input  logic               req,
    input  logic               read,
    input  logic [PAGE_W-1:0]  mempage,
    input  logic [BURST_W-1:0] len,
    input  logic [DATA_W-1:0]  wdata,
    output logic               wdata_pop,
    usb_rw_sequencer_if.master bus,
    output logic [DATA_W-1:0]  rdata,
    output logic               rdata_valid,
    output logic               busy,
    output logic               done,
    output logic               cancel
);

    typedef enum logic [2:0] {
        IDLE, A_ISSUE, A_WAIT, D_ISSUE, D_WAIT, FINISH
    } state_t;

    state_t             state;
    logic               read_q;
    logic [BURST_W-1:0] len_q;
    logic [BURST_W-1:0] word_cnt;
    logic [DATA_W-1:0]  hold_q;
    logic               issue_q;
    logic               send_in_q;
    logic [3:0]         endp_q;
    logic               first_try;
    logic               can_retry;
    logic               accept;

`ifdef USB_RW_RETRY_EN
    localparam int RETRY_W = $clog2(MAX_RETRY + 1);
    logic [RETRY_W-1:0] retry_cnt;

    assign first_try = (retry_cnt == '0);
    assign can_retry = (retry_cnt < RETRY_W'(MAX_RETRY));

    always_ff @(posedge clk or negedge rst_L) begin
        if (!rst_L) begin
            retry_cnt <= '0;
        end else if (state == IDLE && req) begin
            retry_cnt <= '0;
        end else if (state == A_WAIT || state == D_WAIT) begin
            if (bus.bad) begin
                if (can_retry)
                    retry_cnt <= retry_cnt + 1'b1;
            end else if (bus.xfer_done) begin
                retry_cnt <= '0;
            end
        end
    end
`else
    assign first_try = 1'b1;
    assign can_retry = 1'b0;
`endif

    // Payload lives in hold_q from issue until the next word, so a retry re-sends it unchanged.
    assign accept          = issue_q & bus.free;
    assign bus.input_ready = issue_q;
    assign bus.send_in     = send_in_q;
    assign bus.addr        = issue_q ? DEV_ADDR : 7'd0;
    assign bus.endp        = endp_q;
    assign bus.tx_data     = issue_q ? hold_q : '0;
    assign wdata_pop       = accept & (state == D_ISSUE) & ~read_q & first_try;

    always_ff @(posedge clk or negedge rst_L) begin
        if (!rst_L) begin
            state       <= IDLE;
            read_q      <= 1'b0;
            len_q       <= '0;
            word_cnt    <= '0;
            hold_q      <= '0;
            issue_q     <= 1'b0;
            send_in_q   <= 1'b0;
            endp_q      <= 4'd0;
            rdata       <= '0;
            rdata_valid <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            cancel      <= 1'b0;
        end else begin
            rdata_valid <= 1'b0;
            done        <= 1'b0;
            cancel      <= 1'b0;
            case (state)
                IDLE: begin
                    if (req) begin
                        read_q    <= read;
                        len_q     <= len;
                        word_cnt  <= '0;
                        hold_q    <= DATA_W'(mempage);
                        issue_q   <= 1'b1;
                        send_in_q <= 1'b0;
                        endp_q    <= ADDR_ENDP;
                        busy      <= 1'b1;
                        state     <= A_ISSUE;
                    end
                end
                A_ISSUE: begin
                    if (accept) begin
                        issue_q <= 1'b0;
                        endp_q  <= 4'd0;
                        state   <= A_WAIT;
                    end
                end
                A_WAIT: begin
                    if (bus.bad) begin
                        if (can_retry) begin
                            issue_q <= 1'b1;
                            endp_q  <= ADDR_ENDP;
                            state   <= A_ISSUE;
                        end else begin
                            done   <= 1'b1;
                            cancel <= 1'b1;
                            state  <= FINISH;
                        end
                    end else if (bus.xfer_done) begin
                        issue_q   <= 1'b1;
                        send_in_q <= read_q;
                        endp_q    <= DATA_ENDP;
                        hold_q    <= read_q ? '0 : wdata;
                        state     <= D_ISSUE;
                    end
                end
                D_ISSUE: begin
                    if (accept) begin
                        issue_q   <= 1'b0;
                        send_in_q <= 1'b0;
                        endp_q    <= 4'd0;
                        state     <= D_WAIT;
                    end
                end
                D_WAIT: begin
                    if (bus.bad) begin
                        if (can_retry) begin
                            issue_q   <= 1'b1;
                            send_in_q <= read_q;
                            endp_q    <= DATA_ENDP;
                            state     <= D_ISSUE;
                        end else begin
                            done   <= 1'b1;
                            cancel <= 1'b1;
                            state  <= FINISH;
                        end
                    end else if (bus.xfer_done) begin
                        if (read_q) begin
                            rdata       <= bus.rx_data;
                            rdata_valid <= 1'b1;
                        end
                        if (word_cnt == len_q) begin
                            done  <= 1'b1;
                            state <= FINISH;
                        end else begin
                            word_cnt  <= word_cnt + 1'b1;
                            issue_q   <= 1'b1;
                            send_in_q <= read_q;
                            endp_q    <= DATA_ENDP;
                            hold_q    <= read_q ? '0 : wdata;
                            state     <= D_ISSUE;
                        end
                    end
                end
                FINISH: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_usb_rw_sequencer.sv
// Scoreboard bench for usb_rw_sequencer: expected transactions, read words and outcome are
// queued per sequence and compared as the DUT issues them. Honours USB_RW_RETRY_EN.
module tb_usb_rw_sequencer;

    localparam int RESP_OK   = 0;
    localparam int RESP_BAD  = 1;
    localparam int RESP_BOTH = 2;

    logic        clk = 1'b0;
    logic        rst_L = 1'b0;
    logic        req = 1'b0;
    logic        read = 1'b0;
    logic [15:0] mempage = '0;
    logic [2:0]  len = '0;
    logic [63:0] wdata = '0;
    logic        wdata_pop;
    logic [63:0] rdata;
    logic        rdata_valid;
    logic        busy;
    logic        done;
    logic        cancel;

    usb_rw_sequencer_if #(.DATA_W(64)) bus ();

    usb_rw_sequencer dut (
        .clk         (clk),
        .rst_L       (rst_L),
        .req         (req),
        .read        (read),
        .mempage     (mempage),
        .len         (len),
        .wdata       (wdata),
        .wdata_pop   (wdata_pop),
        .bus         (bus.master),
        .rdata       (rdata),
        .rdata_valid (rdata_valid),
        .busy        (busy),
        .done        (done),
        .cancel      (cancel)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        sendIn;
        logic [3:0]  endp;
        logic [63:0] data;
        logic        pop;
    } txn_t;

    txn_t        expTxn[$];
    int          respPlan[$];
    logic [63:0] rxWords[$];
    logic [63:0] expRdata[$];
    logic [63:0] wrWords[0:7];
    int          checks = 0;
    int          errors = 0;

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    task automatic pushTxn(input logic sendIn, input logic [3:0] endp, input logic [63:0] data, input logic pop);
        txn_t t;
        t.sendIn = sendIn;
        t.endp   = endp;
        t.data   = data;
        t.pop    = pop;
        expTxn.push_back(t);
    endtask

    task automatic clearQueues();
        expTxn.delete();
        respPlan.delete();
        rxWords.delete();
        expRdata.delete();
    endtask

    // Plays the protocol FSM for one sequence: stalls free, answers each accept one cycle later.
    task automatic applyStimulus(input logic isRead, input logic [15:0] page, input logic [2:0] lenVal,
                                 input int freeLow, input logic expCancel, input int expLatency,
                                 input int abortAt);
        int          cyc;
        int          code;
        int          stalls;
        int          wrPtr;
        logic        pendingResp;
        logic        popPending;
        logic        lastIn;
        logic        doneSeen;
        logic [63:0] snapData;
        logic [3:0]  snapEndp;
        logic [6:0]  snapAddr;
        txn_t        t;

        wrPtr = 0;
        wdata = wrWords[0];
        @(negedge clk);
        read    = isRead;
        mempage = page;
        len     = lenVal;
        req     = 1'b1;
        @(negedge clk);
        req = 1'b0;
        cyc = 1;
        stalls = 0;
        pendingResp = 1'b0;
        popPending = 1'b0;
        lastIn = 1'b0;
        doneSeen = 1'b0;
        snapData = '0;
        snapEndp = '0;
        snapAddr = '0;

        while (cyc < 400 && !doneSeen) begin
            if (abortAt > 0 && cyc == abortAt) begin
                rst_L = 1'b0;
                bus.xfer_done = 1'b0;
                bus.bad = 1'b0;
                #1;
                checkOutput("abort_input_ready", bus.input_ready, 1'b0);
                checkOutput("abort_busy", busy, 1'b0);
                checkOutput("abort_bus", bus.tx_data | {53'b0, bus.addr, bus.endp}, 64'd0);
                checkOutput("abort_pulses", {wdata_pop, rdata_valid, done, cancel}, 4'd0);
                repeat (3) begin
                    @(negedge clk);
                    checkOutput("abort_no_done", {done, cancel, busy}, 3'd0);
                end
                rst_L = 1'b1;
                clearQueues();
                return;
            end
            if (popPending) begin
                wrPtr++;
                wdata = wrWords[wrPtr % 8];
                popPending = 1'b0;
            end
            bus.xfer_done = 1'b0;
            bus.bad = 1'b0;
            bus.rx_data = 64'hBAD0_BAD0_BAD0_BAD0;
            if (pendingResp) begin
                pendingResp = 1'b0;
                if (respPlan.size() == 0) begin
                    checkOutput("resp_plan_empty", 1'b1, 1'b0);
                end else begin
                    code = respPlan.pop_front();
                    bus.xfer_done = (code != RESP_BAD);
                    bus.bad = (code != RESP_OK);
                    if (code == RESP_OK && lastIn && rxWords.size() > 0)
                        bus.rx_data = rxWords.pop_front();
                end
            end
            bus.free = 1'b1;
            if (bus.input_ready && stalls < freeLow) begin
                if (stalls == 0) begin
                    snapData = bus.tx_data;
                    snapEndp = bus.endp;
                    snapAddr = bus.addr;
                end else begin
                    checkOutput("stall_tx_data", bus.tx_data, snapData);
                    checkOutput("stall_endp", bus.endp, snapEndp);
                    checkOutput("stall_addr", bus.addr, snapAddr);
                end
                bus.free = 1'b0;
                stalls++;
            end
            #1;
            if (bus.input_ready && bus.free) begin
                if (expTxn.size() == 0) begin
                    checkOutput("txn_unexpected", 1'b1, 1'b0);
                end else begin
                    t = expTxn.pop_front();
                    checkOutput("txn_send_in", bus.send_in, t.sendIn);
                    checkOutput("txn_endp", bus.endp, t.endp);
                    checkOutput("txn_tx_data", bus.tx_data, t.data);
                    checkOutput("txn_addr", bus.addr, 7'd5);
                    checkOutput("txn_wdata_pop", wdata_pop, t.pop);
                end
                lastIn = bus.send_in;
                popPending = wdata_pop;
                pendingResp = 1'b1;
            end else begin
                checkOutput("no_accept_wdata_pop", wdata_pop, 1'b0);
                if (!bus.input_ready)
                    checkOutput("idle_bus", bus.tx_data | {52'b0, bus.send_in, bus.addr, bus.endp}, 64'd0);
            end
            if (rdata_valid) begin
                if (expRdata.size() == 0)
                    checkOutput("rdata_spurious", 1'b1, 1'b0);
                else
                    checkOutput("rdata", rdata, expRdata.pop_front());
            end
            if (done) begin
                doneSeen = 1'b1;
                checkOutput("cancel", cancel, expCancel);
                checkOutput("busy_at_done", busy, 1'b1);
                if (expLatency > 0)
                    checkOutput("latency", cyc, expLatency);
                checkOutput("txn_left", expTxn.size(), 0);
                checkOutput("rdata_left", expRdata.size(), 0);
            end else begin
                checkOutput("cancel_without_done", cancel, 1'b0);
            end
            @(negedge clk);
            cyc++;
        end

        bus.xfer_done = 1'b0;
        bus.bad = 1'b0;
        bus.free = 1'b1;
        if (freeLow > 0)
            checkOutput("stall_cycles", stalls, freeLow);
        if (doneSeen) begin
            #1;
            checkOutput("busy_after_done", busy, 1'b0);
            checkOutput("done_pulse_width", done, 1'b0);
        end else begin
            checkOutput("done_timeout", 1'b0, 1'b1);
        end
        clearQueues();
    endtask

    initial begin
        bus.free = 1'b1;
        bus.xfer_done = 1'b0;
        bus.bad = 1'b0;
        bus.rx_data = '0;
        for (int i = 0; i < 8; i++)
            wrWords[i] = 64'h0101_0101_0101_0101 * (i + 1) ^ 64'hC000_0000_0000_0000;

        repeat (3) @(negedge clk);
        checkOutput("reset_busy", busy, 1'b0);
        checkOutput("reset_pulses", {done, cancel, rdata_valid, wdata_pop}, 4'd0);
        checkOutput("reset_rdata", rdata, 64'd0);
        checkOutput("reset_bus", bus.tx_data | {52'b0, bus.input_ready, bus.addr, bus.endp}, 64'd0);
        rst_L = 1'b1;
        @(negedge clk);

        $display("[TB] single-word read");
        pushTxn(1'b0, 4'd4, 64'h1234, 1'b0);
        pushTxn(1'b1, 4'd8, 64'd0, 1'b0);
        respPlan = '{RESP_OK, RESP_OK};
        rxWords.push_back(64'hDEAD);
        expRdata.push_back(64'hDEAD);
        applyStimulus(1'b1, 16'h1234, 3'd0, 0, 1'b0, 5, 0);

        $display("[TB] four-word write");
        pushTxn(1'b0, 4'd4, 64'h00AB, 1'b0);
        for (int i = 0; i < 4; i++) begin
            pushTxn(1'b0, 4'd8, wrWords[i], 1'b1);
        end
        respPlan = '{RESP_OK, RESP_OK, RESP_OK, RESP_OK, RESP_OK};
        applyStimulus(1'b0, 16'h00AB, 3'd3, 0, 1'b0, 11, 0);

        $display("[TB] address stalled by free low");
        pushTxn(1'b0, 4'd4, 64'hBEEF, 1'b0);
        pushTxn(1'b1, 4'd8, 64'd0, 1'b0);
        pushTxn(1'b1, 4'd8, 64'd0, 1'b0);
        respPlan = '{RESP_OK, RESP_OK, RESP_OK};
        rxWords = '{64'h1111, 64'h2222};
        expRdata = '{64'h1111, 64'h2222};
        applyStimulus(1'b1, 16'hBEEF, 3'd1, 10, 1'b0, 0, 0);

        $display("[TB] full-length read burst");
        pushTxn(1'b0, 4'd4, 64'hFFFF, 1'b0);
        respPlan.push_back(RESP_OK);
        for (int i = 0; i < 8; i++) begin
            pushTxn(1'b1, 4'd8, 64'd0, 1'b0);
            respPlan.push_back(RESP_OK);
            rxWords.push_back(64'h5A00_0000_0000_0000 + 64'(i));
            expRdata.push_back(64'h5A00_0000_0000_0000 + 64'(i));
        end
        applyStimulus(1'b1, 16'hFFFF, 3'd7, 0, 1'b0, 19, 0);

`ifdef USB_RW_RETRY_EN
        $display("[TB] write word retried twice");
        pushTxn(1'b0, 4'd4, 64'h0300, 1'b0);
        pushTxn(1'b0, 4'd8, wrWords[0], 1'b1);
        pushTxn(1'b0, 4'd8, wrWords[1], 1'b1);
        pushTxn(1'b0, 4'd8, wrWords[1], 1'b0);
        pushTxn(1'b0, 4'd8, wrWords[1], 1'b0);
        respPlan = '{RESP_OK, RESP_OK, RESP_BAD, RESP_BAD, RESP_OK};
        applyStimulus(1'b0, 16'h0300, 3'd1, 0, 1'b0, 0, 0);

        $display("[TB] address retries exhausted");
        for (int i = 0; i < 4; i++) begin
            pushTxn(1'b0, 4'd4, 64'h0F0F, 1'b0);
            respPlan.push_back(RESP_BAD);
        end
        applyStimulus(1'b1, 16'h0F0F, 3'd0, 0, 1'b1, 0, 0);

        $display("[TB] bad with xfer_done retried as bad");
        pushTxn(1'b0, 4'd4, 64'h0777, 1'b0);
        pushTxn(1'b1, 4'd8, 64'd0, 1'b0);
        pushTxn(1'b1, 4'd8, 64'd0, 1'b0);
        pushTxn(1'b1, 4'd8, 64'd0, 1'b0);
        respPlan = '{RESP_OK, RESP_OK, RESP_BOTH, RESP_OK};
        rxWords = '{64'h11, 64'h22};
        expRdata = '{64'h11, 64'h22};
        applyStimulus(1'b1, 16'h0777, 3'd1, 0, 1'b0, 0, 0);
`else
        $display("[TB] first bad cancels write");
        pushTxn(1'b0, 4'd4, 64'h0300, 1'b0);
        pushTxn(1'b0, 4'd8, wrWords[0], 1'b1);
        respPlan = '{RESP_OK, RESP_BAD};
        applyStimulus(1'b0, 16'h0300, 3'd2, 0, 1'b1, 0, 0);

        $display("[TB] bad with xfer_done cancels read");
        pushTxn(1'b0, 4'd4, 64'h0777, 1'b0);
        pushTxn(1'b1, 4'd8, 64'd0, 1'b0);
        pushTxn(1'b1, 4'd8, 64'd0, 1'b0);
        respPlan = '{RESP_OK, RESP_OK, RESP_BOTH};
        rxWords = '{64'h11, 64'h22};
        expRdata = '{64'h11};
        applyStimulus(1'b1, 16'h0777, 3'd1, 0, 1'b1, 0, 0);
`endif

        $display("[TB] reset mid-burst then normal read");
        pushTxn(1'b0, 4'd4, 64'h0042, 1'b0);
        for (int i = 0; i < 8; i++) begin
            pushTxn(1'b0, 4'd8, wrWords[i], 1'b1);
        end
        respPlan = '{RESP_OK, RESP_OK, RESP_OK, RESP_OK, RESP_OK, RESP_OK, RESP_OK, RESP_OK, RESP_OK};
        applyStimulus(1'b0, 16'h0042, 3'd7, 0, 1'b0, 0, 6);
        pushTxn(1'b0, 4'd4, 64'h0042, 1'b0);
        pushTxn(1'b1, 4'd8, 64'd0, 1'b0);
        respPlan = '{RESP_OK, RESP_OK};
        rxWords.push_back(64'h77);
        expRdata.push_back(64'h77);
        applyStimulus(1'b1, 16'h0042, 3'd0, 0, 1'b0, 5, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
